pe_stream: RTL and testbench
============================

PE_STREAM -- requirements
Module: pe_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed data width of every in*/out* port.
REQ-002 SHALL have parameter TW_WIDTH, default 16: signed width of each twiddle half.
REQ-003 SHALL have parameter SHIFT, default 8: twiddle fractional bits, legal range 1..TW_WIDTH-1.
REQ-004 SHALL have ports:
  Clk  input  1  sole clock, rising edge.
  Reset  input  1  asynchronous, active-high reset.
  in_valid  input  1  input beat present.
  in_ready  output  1  block accepts a beat this cycle.
  in0, in1, in2, in3  input  WIDTH each  signed real samples.
  tf  input  2*TW_WIDTH  twiddle, real in upper half, imaginary in lower half.
  mode  input  2  00 bypass, 01 forward multiply, 10 conjugate multiply, 11 treated as 00.
  scale_en  input  1  halve the butterfly sums and differences.
  out_valid  output  1  output beat present.
  out_ready  input  1  downstream accepts a beat.
  out0, out1, out2, out3  output  WIDTH each  signed results.
  ovf  output  1  sticky saturation flag.
  clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-005 The datapath SHALL be a 3-stage pipeline with enable ce = out_ready OR NOT out_valid; in_ready SHALL equal ce, combinationally.
REQ-006 A beat SHALL be accepted when in_valid AND in_ready; tf, mode and scale_en SHALL be captured with that beat and travel with it.
REQ-007 Latency SHALL be exactly 3 enabled cycles from acceptance to out_valid; with out_ready held high, throughput SHALL be one beat per cycle.
REQ-008 When ce=0, every pipeline register, including the valid bits, SHALL hold; outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-009 Stage 1 SHALL compute at WIDTH+1 bits: s0=in0+in1, d0=in0-in1, s1=in2+in3, d1=in2-in3.
REQ-010 If scale_en=1, each stage-1 result SHALL be arithmetically shifted right by 1 (floor) to WIDTH bits; otherwise each SHALL be saturated to WIDTH bits.
REQ-011 Stage 2 forward mode SHALL compute p2=d0*tr-d1*ti and p3=-(d0*ti+d1*tr) at full width (WIDTH+TW_WIDTH+1).
REQ-012 Stage 2 conjugate mode SHALL compute p2=d0*tr+d1*ti and p3=d0*ti-d1*tr.
REQ-013 Stage 3 SHALL round p2 and p3 half-up (add 2^(SHIFT-1), arithmetic shift right by SHIFT) and then saturate to WIDTH bits.
REQ-014 The outputs SHALL be out0=s0 and out1=s1; out2/out3 SHALL be the rounded products, or d0/d1 unchanged in bypass mode.
REQ-015 ovf SHALL set on any saturation event in a valid beat as it advances, and SHALL stay set until clr_ovf.
REQ-016 If clr_ovf and a new saturation event occur in the same cycle, ovf SHALL end that cycle at 1 (set wins).
REQ-017 Saturation SHALL clamp to +2^(WIDTH-1)-1 and -2^(WIDTH-1); results SHALL never wrap.

Reset
REQ-018 Reset asserted SHALL immediately clear all valid bits, all data registers, out0..out3 and ovf to 0, mid-stream included; in-flight beats SHALL be discarded.
REQ-019 The first beat SHALL be accepted on the first rising edge after Reset deasserts.

Structure
REQ-020 Package pe_pkg SHALL hold the mode encodings (PE_BYPASS, PE_FWD, PE_CONJ) and a saturate-to-WIDTH function.
REQ-021 The complex multiply with round and saturate SHALL be a sub-module, pe_cmul, that is combinational plus one register stage and is enabled by ce.

Verification (WIDTH=16, TW_WIDTH=16, SHIFT=8)
REQ-022 Reset pulse mid-stream -> out_valid=0, out0..3=0 and ovf=0 asynchronously; the next beat emerges after exactly 3 cycles.
REQ-023 Forward: in0..3=100,20,5,3, tf=(256,0), mode=01 -> out0..3=120,8,80,-2.
REQ-024 Conjugate: d0=80, d1=2, tf=(0,256), mode=10 -> out2=2, out3=80; the same beat with mode=01 -> out2=-2, out3=-80.
REQ-025 Saturation: in0=32767, in1=1, scale_en=0 -> out0=32767 and ovf=1 held until clr_ovf; with scale_en=1 -> out0=16384 and ovf unchanged.
REQ-026 Rounding: in0=3, in1=0, tf=(128,0) -> out2=2; in0=-3 -> out2=-1.
REQ-027 Backpressure: send 6 back-to-back beats and drop out_ready for 2 cycles mid-stream -> all 6 beats arrive in order with no loss or duplication, in_ready=0 while stalled with the pipeline full, and outputs stable while stalled.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared mode encodings and saturation helpers for the pe_stream datapath.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_BYPASS = 2'b00,
    PE_FWD    = 2'b01,
    PE_CONJ   = 2'b10
  } pe_mode_e;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] x, input int w);
    return (x > sat_max(w)) || (x < (-sat_max(w) - 64'sd1));
  endfunction

  // Clamp x into the signed w-bit range; caller truncates the result to w bits.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] x, input int w);
    if (x > sat_max(w))
      return sat_max(w);
    else if (x < (-sat_max(w) - 64'sd1))
      return -sat_max(w) - 64'sd1;
    else
      return x;
  endfunction

endpackage

// File: rtl/pe_stream_cmul.sv
// Twiddle multiply (forward or conjugate), one product register, then
// half-up rounding and saturation back to WIDTH bits.
module pe_cmul
  import pe_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int SHIFT    = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      ce,
  input  logic signed [WIDTH-1:0]   d0,
  input  logic signed [WIDTH-1:0]   d1,
  input  logic [2*TW_WIDTH-1:0]     tf,
  input  logic                      conj,
  output logic signed [WIDTH-1:0]   re,
  output logic signed [WIDTH-1:0]   im,
  output logic                      sat
);

  localparam int PW = WIDTH + TW_WIDTH + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (SHIFT - 1);

  logic signed [TW_WIDTH-1:0] tr, ti;
  logic signed [PW-1:0] d0tr, d0ti, d1tr, d1ti;
  logic signed [PW-1:0] p2_n, p3_n, p2_q, p3_q, r2, r3;

  assign tr = tf[2*TW_WIDTH-1:TW_WIDTH];
  assign ti = tf[TW_WIDTH-1:0];

  always_comb begin
    d0tr = PW'(d0) * PW'(tr);
    d0ti = PW'(d0) * PW'(ti);
    d1tr = PW'(d1) * PW'(tr);
    d1ti = PW'(d1) * PW'(ti);
    if (conj) begin
      p2_n = d0tr + d1ti;
      p3_n = d0ti - d1tr;
    end else begin
      p2_n = d0tr - d1ti;
      p3_n = -(d0ti + d1tr);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      p2_q <= '0;
      p3_q <= '0;
    end else if (ce) begin
      p2_q <= p2_n;
      p3_q <= p3_n;
    end
  end

  // PW leaves headroom for the rounding constant, so this add cannot wrap.
  assign r2  = (p2_q + RND) >>> SHIFT;
  assign r3  = (p3_q + RND) >>> SHIFT;
  assign re  = WIDTH'(sat_to(64'(r2), WIDTH));
  assign im  = WIDTH'(sat_to(64'(r3), WIDTH));
  assign sat = sat_hit(64'(r2), WIDTH) | sat_hit(64'(r3), WIDTH);

endmodule

// File: rtl/pe_stream.sv
// Radix-2 butterfly pair with optional twiddle multiply on the differences,
// three-stage pipeline with a single global enable driven by output backpressure.
module pe_stream
  import pe_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TW_WIDTH = 16,
  parameter int SHIFT    = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [WIDTH-1:0]  in0,
  input  logic signed [WIDTH-1:0]  in1,
  input  logic signed [WIDTH-1:0]  in2,
  input  logic signed [WIDTH-1:0]  in3,
  input  logic [2*TW_WIDTH-1:0]    tf,
  input  logic [1:0]               mode,
  input  logic                     scale_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WIDTH-1:0]  out0,
  output logic signed [WIDTH-1:0]  out1,
  output logic signed [WIDTH-1:0]  out2,
  output logic signed [WIDTH-1:0]  out3,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int W1 = WIDTH + 1;

  logic ce;
  logic signed [W1-1:0]    bf   [4];
  logic signed [WIDTH-1:0] bf_n [4];
  logic [3:0]              bf_sat;

  logic                    v1, sat1;
  logic signed [WIDTH-1:0] s0_1, d0_1, s1_1, d1_1;
  logic [2*TW_WIDTH-1:0]   tf1;
  logic [1:0]              mode1;

  logic                    v2, sat2, byp2;
  logic signed [WIDTH-1:0] s0_2, d0_2, s1_2, d1_2;
  logic [1:0]              mode2;

  logic signed [WIDTH-1:0] c2, c3;
  logic                    csat, sat3;

  assign ce       = out_ready | ~out_valid;
  assign in_ready = ce;

  always_comb begin
    bf[0] = W1'(in0) + W1'(in1);
    bf[1] = W1'(in0) - W1'(in1);
    bf[2] = W1'(in2) + W1'(in3);
    bf[3] = W1'(in2) - W1'(in3);
    bf_sat = '0;
    for (int i = 0; i < 4; i++) begin
      if (scale_en) begin
        bf_n[i] = WIDTH'(bf[i] >>> 1);
      end else begin
        bf_n[i]   = WIDTH'(sat_to(64'(bf[i]), WIDTH));
        bf_sat[i] = sat_hit(64'(bf[i]), WIDTH);
      end
    end
  end

  pe_cmul #(
    .WIDTH    (WIDTH),
    .TW_WIDTH (TW_WIDTH),
    .SHIFT    (SHIFT)
  ) u_cmul (
    .Clk   (Clk),
    .Reset (Reset),
    .ce    (ce),
    .d0    (d0_1),
    .d1    (d1_1),
    .tf    (tf1),
    .conj  (mode1 == PE_CONJ),
    .re    (c2),
    .im    (c3),
    .sat   (csat)
  );

  // Mode 11 falls through to bypass along with 00.
  assign byp2 = (mode2 != PE_FWD) && (mode2 != PE_CONJ);
  assign sat3 = sat2 | (~byp2 & csat);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1 <= 1'b0;  sat1 <= 1'b0;  tf1 <= '0;  mode1 <= '0;
      s0_1 <= '0;  d0_1 <= '0;   s1_1 <= '0; d1_1 <= '0;
      v2 <= 1'b0;  sat2 <= 1'b0;  mode2 <= '0;
      s0_2 <= '0;  d0_2 <= '0;   s1_2 <= '0; d1_2 <= '0;
      out_valid <= 1'b0;
      out0 <= '0;  out1 <= '0;   out2 <= '0; out3 <= '0;
    end else if (ce) begin
      v1    <= in_valid;
      sat1  <= in_valid & (|bf_sat);
      tf1   <= tf;
      mode1 <= mode;
      s0_1  <= bf_n[0];
      d0_1  <= bf_n[1];
      s1_1  <= bf_n[2];
      d1_1  <= bf_n[3];

      v2    <= v1;
      sat2  <= v1 & sat1;
      mode2 <= mode1;
      s0_2  <= s0_1;
      d0_2  <= d0_1;
      s1_2  <= s1_1;
      d1_2  <= d1_1;

      out_valid <= v2;
      out0      <= s0_2;
      out1      <= s1_2;
      out2      <= byp2 ? d0_2 : c2;
      out3      <= byp2 ? d1_2 : c3;
    end
  end

  // A saturating beat landing in the output register beats a same-cycle clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      ovf <= 1'b0;
    else if (ce && v2 && sat3)
      ovf <= 1'b1;
    else if (clr_ovf)
      ovf <= 1'b0;
  end

endmodule

// File: tb/tb_pe_stream.sv
// Directed bench for pe_stream: vector table plus reset, saturation, set-wins
// and backpressure sequences.
module tb_pe_stream;

  typedef struct {
    logic signed [15:0] i0, i1, i2, i3;
    logic [31:0]        tf;
    logic [1:0]         mode;
    logic               sc;
    logic signed [15:0] e0, e1, e2, e3;
    logic               eo;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1, scale_en = 1'b0, clr_ovf = 1'b0;
  logic in_ready, out_valid, ovf;
  logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic signed [15:0] out0, out1, out2, out3;
  logic [31:0] tf = '0;
  logic [1:0]  mode = '0;

  int errors = 0;
  int checks = 0;
  vec_t vt[12];

  always #5 Clk = ~Clk;

  pe_stream #(.WIDTH(16), .TW_WIDTH(16), .SHIFT(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .tf(tf), .mode(mode), .scale_en(scale_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  function automatic vec_t mk(int a, int b, int c, int d, int tr, int ti, int m, int sc,
                              int e0, int e1, int e2, int e3, int eo);
    vec_t v;
    v.i0 = 16'(a);  v.i1 = 16'(b);  v.i2 = 16'(c);  v.i3 = 16'(d);
    v.tf = {16'(tr), 16'(ti)};
    v.mode = 2'(m);
    v.sc = 1'(sc);
    v.e0 = 16'(e0); v.e1 = 16'(e1); v.e2 = 16'(e2); v.e3 = 16'(e3);
    v.eo = 1'(eo);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input vec_t v);
    in0 = v.i0; in1 = v.i1; in2 = v.i2; in3 = v.i3;
    tf = v.tf; mode = v.mode; scale_en = v.sc;
  endtask

  task automatic send_check(input vec_t v, input string nm);
    load(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({nm, " early valid"}, int'(out_valid), 0);
    step();
    chk({nm, " out_valid"}, int'(out_valid), 1);
    chk({nm, " out0"}, out0, v.e0);
    chk({nm, " out1"}, out1, v.e1);
    chk({nm, " out2"}, out2, v.e2);
    chk({nm, " out3"}, out3, v.e3);
    chk({nm, " ovf"}, int'(ovf), int'(v.eo));
  endtask

  task automatic clear_ovf(input string nm);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk({nm, " ovf cleared"}, int'(ovf), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tx, rx;
    logic held;
    logic signed [15:0] h0, h1;

    vt[0]  = mk(100, 20, 5, 3, 256, 0, 1, 0, 120, 8, 80, -2, 0);
    vt[1]  = mk(100, 20, 5, 3, 0, 256, 2, 0, 120, 8, 2, 80, 0);
    vt[2]  = mk(100, 20, 5, 3, 0, 256, 1, 0, 120, 8, -2, -80, 0);
    vt[3]  = mk(100, 20, 5, 3, 0, 0, 0, 0, 120, 8, 80, 2, 0);
    vt[4]  = mk(100, 20, 5, 3, 256, 256, 3, 0, 120, 8, 80, 2, 0);
    vt[5]  = mk(3, 0, 0, 0, 128, 0, 1, 0, 3, 0, 2, 0, 0);
    vt[6]  = mk(-3, 0, 0, 0, 128, 0, 1, 0, -3, 0, -1, 0, 0);
    vt[7]  = mk(100, 20, 5, 3, 0, 0, 0, 1, 60, 4, 40, 1, 0);
    vt[8]  = mk(5, 2, -3, 0, 0, 0, 0, 1, 3, -2, 1, -2, 0);
    vt[9]  = mk(-32768, 1, 0, 0, 0, 0, 0, 0, -32767, 0, -32768, 0, 1);
    vt[10] = mk(1000, 0, 0, 0, 32767, 0, 1, 0, 1000, 0, 32767, 0, 1);
    vt[11] = mk(1000, 0, 0, 0, -32768, 0, 1, 0, 1000, 0, -32768, 0, 1);

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out0", out0, 0);
    chk("rst out3", out3, 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst in_ready", int'(in_ready), 1);

    for (int i = 0; i < 12; i++) begin
      send_check(vt[i], $sformatf("vec%0d", i));
      if (vt[i].eo) clear_ovf($sformatf("vec%0d", i));
    end

    // Sticky ovf: hold through idle and a scaled beat, then clear
    send_check(mk(32767, 1, 0, 0, 0, 0, 0, 0, 32767, 0, 32766, 0, 1), "sat");
    step();
    step();
    chk("sat ovf held idle", int'(ovf), 1);
    send_check(mk(32767, 1, 0, 0, 0, 0, 0, 1, 16384, 0, 16383, 0, 1), "sat scaled");
    clear_ovf("sat");

    // Clear and new saturation in the same cycle: set wins
    load(mk(32767, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("setwins ovf", int'(ovf), 1);
    clear_ovf("setwins");

    // Asynchronous reset mid-stream
    load(mk(32767, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    step();
    load(vt[3]);
    step();
    step();
    chk("midrst ovf before", int'(ovf), 1);
    step();
    in_valid = 1'b0;
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst out0", out0, 0);
    chk("midrst out1", out1, 0);
    chk("midrst out2", out2, 0);
    chk("midrst out3", out3, 0);
    chk("midrst ovf", int'(ovf), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    load(vt[0]);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("postrst valid c1", int'(out_valid), 0);
    step();
    chk("postrst valid c2", int'(out_valid), 0);
    step();
    chk("postrst valid c3", int'(out_valid), 1);
    chk("postrst out2", out2, 80);
    chk("postrst out3", out3, -2);
    step();
    chk("postrst drained", int'(out_valid), 0);

    // Backpressure: 6 beats back-to-back, out_ready low for two cycles
    tx = 0;
    rx = 0;
    held = 1'b0;
    h0 = '0;
    h1 = '0;
    mode = 2'b00;
    scale_en = 1'b0;
    tf = '0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c == 4 || c == 5);
      in_valid = (tx < 6);
      in0 = 16'(100 * (tx + 1));
      in1 = '0;
      in2 = 16'(tx + 1);
      in3 = '0;
      #1;
      if (!out_ready && out_valid) begin
        chk($sformatf("bp stall c%0d in_ready", c), int'(in_ready), 0);
        if (held) begin
          chk($sformatf("bp stall c%0d out0 stable", c), out0, h0);
          chk($sformatf("bp stall c%0d out1 stable", c), out1, h1);
        end
        h0 = out0;
        h1 = out1;
        held = 1'b1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp beat%0d out0", rx), out0, 100 * (rx + 1));
        chk($sformatf("bp beat%0d out1", rx), out1, rx + 1);
        rx++;
      end
      if (in_valid && in_ready) tx++;
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp stall seen", int'(held), 1);
    chk("bp beats sent", tx, 6);
    chk("bp beats received", rx, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
